flit_deserializer: RTL and testbench
====================================

Name: flit_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer for the NoC link receive path. It accepts IN_W-bit beats on a valid/ready stream and assembles each group of OUT_W/IN_W beats into one OUT_W-bit flit. The assembled flit is presented on a registered valid/ready output toward the router input buffer. It sustains one beat per cycle under continuous back-to-back traffic and propagates downstream backpressure to the link.

Parameters:
IN_W, 4, beat width in bits; must be at least 1.
OUT_W, 32, flit width in bits; must be an integer multiple of IN_W.
LSB_FIRST, 1, 1: first beat of a flit lands in bits [IN_W-1:0]; 0: first beat lands in bits [OUT_W-1:OUT_W-IN_W].
BEATS (localparam), OUT_W/IN_W, number of beats per flit.
CW (localparam), max(1, clog2(BEATS)), width of the beat counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  IN_W  beat payload.
in_valid  input  1  beat present.
in_ready  output  1  deserializer can accept a beat this cycle.
out_data  output  OUT_W  assembled flit, registered.
out_valid  output  1  out_data holds a complete flit.
out_ready  input  1  downstream consumer accepts the flit.
beat_cnt  output  CW  number of beats held in the accumulator (0..BEATS-1).

Behaviour:
- Reset (synchronous, active-high, on clk):
  - beat_cnt=0, accumulator=0, out_data=0, out_valid=0.
  - in_ready is combinational and evaluates to 1 once reset is low.
  - Reset asserted mid-flit discards the partial accumulator and any pending out_data; no flit is emitted.
- Beat acceptance (acc): acc = in_valid & in_ready. Each accepted beat is written into the accumulator.
  - LSB_FIRST=1: accumulator <= {in_data, accumulator[OUT_W-1:IN_W]}.
  - LSB_FIRST=0: accumulator <= {accumulator[OUT_W-IN_W-1:0], in_data}.
- Beat counter:
  - On acc with beat_cnt<BEATS-1: beat_cnt increments.
  - On acc with beat_cnt==BEATS-1 (completing beat): beat_cnt wraps to 0.
- Completion:
  - The completing beat is merged directly into out_data in the same edge, so out_data equals the fully shifted word.
  - out_valid rises on the next cycle, giving 1 cycle of latency from the last-beat handshake to out_valid.
  - The accumulator is cleared to 0 on completion.
- Output register:
  - out_valid clears on an out_valid & out_ready handshake, unless a new flit completes in the same cycle, in which case out_valid stays 1 and out_data takes the new flit.
  - out_data is stable while out_valid & !out_ready.
- in_ready = !(beat_cnt==BEATS-1 && out_valid && !out_ready).
  - Only the completing beat is stalled. Non-final beats are always accepted, so up to BEATS-1 beats buffer behind a held flit.
  - Sustained throughput is 1 flit per BEATS cycles with out_ready=1.
- Edge cases:
  - in_valid=0 holds all state.
  - BEATS==1: every accepted beat completes a flit, and in_ready = !(out_valid & !out_ready).
  - in_data is ignored when acc=0.

Optional Feature:
DESER_FLUSH_EN
- Defined:
  - Adds input port in_last (1 bit). An accepted beat with in_last=1 completes the flit immediately, whatever the value of beat_cnt.
  - Missing beats are zero-filled. Received beats sit in the positions they would occupy in a full flit (LSB_FIRST=1: the low beat_cnt+1 beats; LSB_FIRST=0: the high ones).
  - beat_cnt returns to 0.
  - The in_ready stall condition also applies to any beat with in_last=1.
  - in_last on the beat that completes a flit anyway (beat_cnt==BEATS-1) has no extra effect.
- Not defined: the in_last port is absent, and flits complete only after BEATS beats.

Test Plan:
- Reset, then stream beats 0x1..0x8 back-to-back with out_ready=1, defaults. Required: out_valid=1 for exactly 1 cycle, 1 cycle after the 8th beat, with out_data=0x87654321. in_ready stays 1 throughout.
- Same stream with LSB_FIRST=0. Required: out_data=0x12345678.
- Send 16 beats 0x0..0xF with out_ready=0. Required:
  - first flit 0x76543210 held stable on out_data;
  - beats 8..14 accepted, beat_cnt=7;
  - in_ready=0 while beat 15 is offered.
  - Raise out_ready for 1 cycle: beat 15 is accepted that same cycle, and out_data=0xFEDCBA98 with out_valid=1 on the next cycle.
- Assert reset for 1 cycle after 3 beats. Required: beat_cnt=0, and no flit is emitted. A fresh 8-beat stream of 0xA yields 0xAAAAAAAA.
- Continuous in_valid=1 with out_ready=1 for 80 cycles. Required: 10 flits, no in_ready deassertion, and out_valid high exactly 10 cycles.
- With DESER_FLUSH_EN, send beats 0x3,0x2,0x1, with in_last=1 on 0x1. Required: out_data=0x00000123 one cycle later, and beat_cnt=0.

Source files
------------

// File: rtl/flit_deserializer.sv
// flit_deserializer: assembles OUT_W/IN_W serial IN_W-bit beats into one registered OUT_W-bit flit.
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready beat stream;
//        out_data/out_valid/out_ready flit stream; beat_cnt beats held in the accumulator.
// Optional macro DESER_FLUSH_EN adds in_last, which completes a short flit with zero-filled missing beats.
module flit_deserializer #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 32,
    parameter int LSB_FIRST = 1,
    localparam int BEATS    = OUT_W / IN_W,
    localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DESER_FLUSH_EN
    input  logic             in_last,
`endif
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    beat_cnt
);
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d, shifted, flit;
    logic             out_valid_q, out_valid_d, fin, acc, done;
    int               sh;

`ifdef DESER_FLUSH_EN
    assign fin = (beat_cnt_q == CW'(BEATS - 1)) || in_last;
`else
    assign fin = (beat_cnt_q == CW'(BEATS - 1));
`endif

    // Only a flit-completing beat can be stalled; earlier beats always fit in the accumulator.
    assign in_ready  = !(fin && out_valid_q && !out_ready);
    assign acc       = in_valid && in_ready;
    assign done      = acc && fin;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign beat_cnt  = beat_cnt_q;

    always_comb begin
        shifted     = LSB_FIRST != 0 ? OUT_W'({in_data, acc_q} >> IN_W) : OUT_W'({acc_q, in_data});
        // A short (flushed) flit is realigned so received beats sit where a full flit would put them;
        // on a full flit the shift is zero.
        sh          = (BEATS - 1 - int'(beat_cnt_q)) * IN_W;
        flit        = LSB_FIRST != 0 ? shifted >> sh : shifted << sh;
        beat_cnt_d  = acc ? (fin ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
        acc_d       = acc ? (fin ? '0 : shifted) : acc_q;
        out_data_d  = done ? flit : out_data_q;
        out_valid_d = done || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_flit_deserializer.sv
// tb_flit_deserializer: scoreboard bench driving an LSB-first and an MSB-first deserializer in parallel.
module tb_flit_deserializer;
    localparam int IN_W  = 4;
    localparam int OUT_W = 32;
    localparam int BEATS = OUT_W / IN_W;
    localparam int CW    = 3;
`ifdef DESER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic             clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, in_last = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready0, in_ready1, out_valid0, out_valid1;
    logic [OUT_W-1:0] out_data0, out_data1;
    logic [CW-1:0]    beat_cnt0, beat_cnt1;

    int n_chk = 0, n_fail = 0, valid_hi = 0, ready_lo = 0;
    bit out_full = 1'b0, rdy_seen;
    logic [IN_W-1:0]  beats[$];
    logic [OUT_W-1:0] exp_q0[$], exp_q1[$];

    always #5 clk = ~clk;

    flit_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
`ifdef DESER_FLUSH_EN
        .in_last(in_last),
`endif
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .beat_cnt(beat_cnt0));

    flit_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
`ifdef DESER_FLUSH_EN
        .in_last(in_last),
`endif
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .beat_cnt(beat_cnt1));

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Beat i of the flit occupies slot i (LSB-first) or slot BEATS-1-i (MSB-first); absent beats stay zero.
    function automatic logic [OUT_W-1:0] assemble(bit lsb);
        logic [OUT_W-1:0] f = '0;
        for (int i = 0; i < beats.size(); i++)
            f |= OUT_W'(beats[i]) << ((lsb ? i : BEATS - 1 - i) * IN_W);
        return f;
    endfunction

    task automatic step(bit v, logic [IN_W-1:0] d, bit r, bit l);
        bit fin, exp_rdy, acc;
        @(posedge clk); #1;
        chk("out_valid0", out_valid0, out_full);
        chk("out_valid1", out_valid1, out_full);
        chk("beat_cnt0", beat_cnt0, beats.size());
        chk("beat_cnt1", beat_cnt1, beats.size());
        if (out_valid0) valid_hi++;
        in_valid = v; in_data = d; out_ready = r; in_last = v && l;
        #2;
        fin     = (beats.size() == BEATS - 1) || (FLUSH && in_last);
        exp_rdy = !(fin && out_full && !r);
        chk("in_ready0", in_ready0, exp_rdy);
        chk("in_ready1", in_ready1, exp_rdy);
        rdy_seen = in_ready0;
        if (!in_ready0) ready_lo++;
        acc = v && exp_rdy;
        if (acc) begin
            beats.push_back(d);
            if (fin) begin
                exp_q0.push_back(assemble(1));
                exp_q1.push_back(assemble(0));
                beats.delete();
            end
        end
        out_full = (acc && fin) || (out_full && !r);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        beats.delete(); exp_q0.delete(); exp_q1.delete(); out_full = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: a presented flit must match the scoreboard head; it is retired on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid0) begin
                if (exp_q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL flit0_unexpected: got %0h expected none", out_data0);
                end else begin
                    chk("flit0_data", out_data0, exp_q0[0]);
                    if (out_ready) void'(exp_q0.pop_front());
                end
            end
            if (out_valid1) begin
                if (exp_q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL flit1_unexpected: got %0h expected none", out_data1);
                end else begin
                    chk("flit1_data", out_data1, exp_q1[0]);
                    if (out_ready) void'(exp_q1.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();
        step(0, 0, 0, 0);
        chk("reset_out_data", out_data0, 0);
        chk("reset_in_ready", in_ready0, 1);

        for (int i = 1; i <= 8; i++) step(1, IN_W'(i), 1, 0);
        step(0, 0, 1, 0);
        chk("lsb_flit", out_data0, 32'h87654321);
        chk("msb_flit", out_data1, 32'h12345678);
        chk("lsb_flit_valid", out_valid0, 1);
        step(0, 0, 1, 0);
        chk("flit_one_cycle", out_valid0, 0);

        for (int i = 0; i < 15; i++) step(1, IN_W'(i), 0, 0);
        step(1, 4'hF, 0, 0);
        chk("stall_ready", rdy_seen, 0);
        chk("held_flit", out_data0, 32'h76543210);
        chk("held_cnt", beat_cnt0, 7);
        step(1, 4'hF, 1, 0);
        chk("release_ready", rdy_seen, 1);
        step(0, 0, 0, 0);
        chk("second_flit", out_data0, 32'hFEDCBA98);
        chk("second_valid", out_valid0, 1);
        step(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, IN_W'(i + 5), 1, 0);
        do_reset();
        step(0, 0, 1, 0);
        chk("midflit_reset_cnt", beat_cnt0, 0);
        for (int i = 0; i < 8; i++) step(1, 4'hA, 1, 0);
        step(0, 0, 1, 0);
        chk("after_reset_flit", out_data0, 32'hAAAAAAAA);
        step(0, 0, 1, 0);

        valid_hi = 0; ready_lo = 0;
        for (int i = 0; i < 80; i++) step(1, IN_W'($urandom), 1, 0);
        step(0, 0, 1, 0);
        chk("tput_valid_cycles", valid_hi, 10);
        chk("tput_ready_drops", ready_lo, 0);

`ifdef DESER_FLUSH_EN
        do_reset();
        step(1, 4'h3, 1, 0);
        step(1, 4'h2, 1, 0);
        step(1, 4'h1, 1, 1);
        step(0, 0, 1, 0);
        chk("flush_flit_lsb", out_data0, 32'h00000123);
        chk("flush_flit_msb", out_data1, 32'h32100000);
        chk("flush_cnt", beat_cnt0, 0);
`endif

        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(3) != 0, IN_W'($urandom), $urandom_range(2) != 0, $urandom_range(5) == 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
